game_countdown_timer: RTL

- Downstream consumer of the 1 ms tick generator. Counts 1 ms ticks into seconds and runs a loadable M:SS BCD countdown for the game round.
- Flags a low-time warning and an expiry event.
- Drives the tick generator's enable, so ms ticks are only produced while the round is running.

---
 rtl/game_countdown_timer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: loadable M:SS BCD countdown for a game round.
// Counts 1 ms ticks into seconds, flags a low-time warning and an expiry
// pulse, and gates the upstream ms tick generator through tick_enable.
// Optional feature macro: COUNTDOWN_BONUS_EN (adds add_bonus, +10 s).
module game_countdown_timer #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int WARN_SEC      = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ms_tick,
   input  logic       start,
   input  logic       pause,
`ifdef COUNTDOWN_BONUS_EN
   input  logic       add_bonus,
`endif
   input  logic [3:0] load_min,
   input  logic [2:0] load_sec_tens,
   input  logic [3:0] load_sec_ones,
   output logic       tick_enable,
   output logic [3:0] min_bcd,
   output logic [2:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       paused,
   output logic       warn,
   output logic       expired,
   output logic       done
);

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] m;
      logic [2:0] t;
      logic [3:0] o;
   } bcd_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] ms_cnt, ms_nxt;
   bcd_t             time_cur, time_nxt;
   logic             exp_nxt;
   logic             warn_nxt;

   // Load values outside the BCD digit ranges saturate to the digit maximum.
   function automatic bcd_t clamp_load(input logic [3:0] m, input logic [2:0] t,
                                       input logic [3:0] o);
      bcd_t r;
      r.m = (m > 4'd9) ? 4'd9 : m;
      r.t = (t > 3'd5) ? 3'd5 : t;
      r.o = (o > 4'd9) ? 4'd9 : o;
      return r;
   endfunction

   // One-second BCD decrement with borrow; only called on a non-zero time.
   function automatic bcd_t bcd_dec(input bcd_t v);
      bcd_t r;
      r = v;
      if (v.o != 4'd0) begin
         r.o = v.o - 4'd1;
      end else begin
         r.o = 4'd9;
         if (v.t != 3'd0) begin
            r.t = v.t - 3'd1;
         end else begin
            r.t = 3'd5;
            r.m = v.m - 4'd1;
         end
      end
      return r;
   endfunction

   // Ten-second BCD increment, saturating at 9:59.
   function automatic bcd_t bcd_add10_sat(input bcd_t v);
      bcd_t r;
      r = v;
      if (v.t == 3'd5) begin
         if (v.m == 4'd9) begin
            r = '{m: 4'd9, t: 3'd5, o: 4'd9};
         end else begin
            r.t = 3'd0;
            r.m = v.m + 4'd1;
         end
      end else begin
         r.t = v.t + 3'd1;
      end
      return r;
   endfunction

   // Low-time test: under one minute and at or below the warning threshold.
   function automatic logic warn_level(input bcd_t v);
      logic [6:0] secs;
      secs = 7'(v.t) * 7'd10 + 7'(v.o);
      return (v.m == 4'd0) && (secs <= 7'(WARN_SEC));
   endfunction

   assign time_cur = {min_bcd, sec_tens, sec_ones};

   // Next-state, next-time and next-output computation; start overrides all.
   always_comb begin
      state_nxt = state;
      ms_nxt    = ms_cnt;
      time_nxt  = time_cur;
      exp_nxt   = 1'b0;
      if (start) begin
         time_nxt = clamp_load(load_min, load_sec_tens, load_sec_ones);
         ms_nxt   = '0;
         if (time_nxt == '0) begin
            state_nxt = ST_DONE;
            exp_nxt   = 1'b1;
         end else begin
            state_nxt = ST_RUN;
         end
      end else begin
         unique case (state)
            ST_RUN: begin
               if (ms_tick) begin
                  if (ms_cnt == CNT_LAST) begin
                     ms_nxt   = '0;
                     time_nxt = bcd_dec(time_cur);
                  end else begin
                     ms_nxt = ms_cnt + CNT_W'(1);
                  end
               end
`ifdef COUNTDOWN_BONUS_EN
               if (add_bonus) time_nxt = bcd_add10_sat(time_nxt);
`endif
               if (time_nxt == '0) begin
                  state_nxt = ST_DONE;
                  exp_nxt   = 1'b1;
               end else if (pause) begin
                  state_nxt = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
`ifdef COUNTDOWN_BONUS_EN
               if (add_bonus) time_nxt = bcd_add10_sat(time_nxt);
`endif
               if (pause) state_nxt = ST_RUN;
            end
            default: begin
            end
         endcase
      end
      warn_nxt = ((state_nxt == ST_RUN) || (state_nxt == ST_PAUSE)) && warn_level(time_nxt);
   end

   // State, counter and all outputs registered; active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         ms_cnt      <= '0;
         min_bcd     <= 4'd0;
         sec_tens    <= 3'd0;
         sec_ones    <= 4'd0;
         tick_enable <= 1'b0;
         running     <= 1'b0;
         paused      <= 1'b0;
         warn        <= 1'b0;
         expired     <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         ms_cnt      <= ms_nxt;
         min_bcd     <= time_nxt.m;
         sec_tens    <= time_nxt.t;
         sec_ones    <= time_nxt.o;
         tick_enable <= (state_nxt == ST_RUN);
         running     <= (state_nxt == ST_RUN);
         paused      <= (state_nxt == ST_PAUSE);
         warn        <= warn_nxt;
         expired     <= exp_nxt;
         done        <= (state_nxt == ST_DONE);
      end
   end

endmodule
